// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES ripple slices of
// C = WIDTH/STAGES bits, with a register after every slice. It takes one
// operation per cycle through a valid/ready handshake with back-pressure.
// Optional feature macro: PIPELINED_ADDER_SUB_EN adds an in_sub input
// that turns an operation into A-B (invert B, force carry-in to 1).

module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int C = WIDTH / STAGES;

    // Per-stage slot registers. Each slot keeps the full-width operands and
    // partial sum. Sum bits above the chunks added so far are still zero,
    // and operand bits below them are no longer read.
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  opA_q   [STAGES];
    logic [WIDTH-1:0]  opB_q   [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] msbCin_q;

    // Values presented to each stage: the block inputs for stage 0 and the
    // previous slot for every later stage.
    logic [STAGES-1:0] srcValid;
    logic [WIDTH-1:0]  srcA    [STAGES];
    logic [WIDTH-1:0]  srcB    [STAGES];
    logic [WIDTH-1:0]  srcSum  [STAGES];
    logic [STAGES-1:0] srcCarry;
    logic [STAGES-1:0] srcMsbCin;

    // Next-state values produced by each stage's ripple slice.
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] msbCin_d;

    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  stage0B;
    logic              stage0Cin;

    // Stage-0 operand conditioning: subtraction feeds ~B with a forced
    // carry-in, so later stages never need to know the operation type.
    always_comb begin
        stage0B   = in_b;
        stage0Cin = in_cin;
`ifdef PIPELINED_ADDER_SUB_EN
        if (in_sub) begin
            stage0B   = ~in_b;
            stage0Cin = 1'b1;
        end
`endif
    end

    // Route each stage's source: the inputs for stage 0, the upstream slot otherwise.
    always_comb begin
        srcValid[0]  = in_valid;
        srcA[0]      = in_a;
        srcB[0]      = stage0B;
        srcSum[0]    = '0;
        srcCarry[0]  = stage0Cin;
        srcMsbCin[0] = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            srcValid[k]  = valid_q[k-1];
            srcA[k]      = opA_q[k-1];
            srcB[k]      = opB_q[k-1];
            srcSum[k]    = sum_q[k-1];
            srcCarry[k]  = carry_q[k-1];
            srcMsbCin[k] = msbCin_q[k-1];
        end
    end

    // Each stage ripples its C-bit chunk through full-adder cells and also
    // records the carry entering bit WIDTH-1 for the overflow flag.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            logic carry;
            carry       = srcCarry[k];
            sum_d[k]    = srcSum[k];
            msbCin_d[k] = srcMsbCin[k];
            for (int i = 0; i < C; i++) begin
                int idx;
                idx = k * C + i;
                if (idx == WIDTH - 1) begin
                    msbCin_d[k] = carry;
                end
                sum_d[k][idx] = srcA[k][idx] ^ srcB[k][idx] ^ carry;
                carry = (srcA[k][idx] & srcB[k][idx]) |
                        (carry & (srcA[k][idx] ^ srcB[k][idx]));
            end
            carry_d[k] = carry;
        end
    end

    // Ready chain from the output back to the input. A stage can load when
    // it is empty or when its contents move on this same cycle.
    always_comb begin
        logic r;
        r = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = !valid_q[k] || r;
            rdy[k] = r;
        end
    end

    assign in_ready = rdy[0];

    // Slot update: reset clears everything. A ready stage takes the upstream
    // valid bit, and takes the upstream data only when that bit is set.
    // Bubbles therefore leave the last result in place.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= '0;
            carry_q  <= '0;
            msbCin_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                opA_q[k] <= '0;
                opB_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    valid_q[k] <= srcValid[k];
                    if (srcValid[k]) begin
                        sum_q[k]    <= sum_d[k];
                        opA_q[k]    <= srcA[k];
                        opB_q[k]    <= srcB[k];
                        carry_q[k]  <= carry_d[k];
                        msbCin_q[k] <= msbCin_d[k];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = carry_q[STAGES-1];
    assign out_ovf   = carry_q[STAGES-1] ^ msbCin_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors with hand-computed results. The
// stimulus pushes each accepted operation's expected result onto a queue,
// and an independent monitor pops and compares on every output transfer.

module tb_pipelined_adder;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_cin = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
`ifdef PIPELINED_ADDER_SUB_EN
    logic        in_sub = 1'b0;
`endif
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int          errors = 0;
    int          checks = 0;
    logic [33:0] sbQ[$];
    vec_t        vecs[19];
    vec_t        idle = '0;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Free-running clock with a 10-unit period.
    always #5 clock = ~clock;

    // Compare one value, and report and count it on a difference.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one operation just after a falling edge. It counts as accepted
    // when in_ready is high with it, and then its expected result is queued.
    task automatic applyStimulus(input vec_t v, input logic valid, output logic accepted);
        in_valid = valid;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
`ifdef PIPELINED_ADDER_SUB_EN
        in_sub   = v.sub;
`endif
        #1;
        accepted = valid && in_ready;
        if (accepted) begin
            sbQ.push_back({v.cout, v.ovf, v.sum});
        end
    endtask

    // Monitor: every output transfer must match the oldest queued expectation.
    initial begin
        logic [33:0] exp;
        forever begin
            @(negedge clock);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected result: got sum 0x%0h, expected no output",
                             out_sum);
                end else begin
                    exp = sbQ.pop_front();
                    checkOutput("result {cout,ovf,sum}", {30'h0, out_cout, out_ovf, out_sum},
                                {30'h0, exp});
                end
            end
        end
    end

    // Absolute time guard so that a stuck handshake cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic        acc;
        int          cyc;
        int          idx;
        int          readyLow;
        int          stale;
        logic        done;
        logic [23:0] validSeen;
        logic [31:0] heldSum;

        //           a             b             cin   sub   sum           cout  ovf
        vecs[0]  = '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[2]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[3]  = '{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[8]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[9]  = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[11] = '{32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[12] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[13] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[14] = '{32'hDEADBEEF, 32'h00000001, 1'b0, 1'b0, 32'hDEADBEF0, 1'b0, 1'b0};
        vecs[15] = '{32'h00000080, 32'h00000080, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[16] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[17] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[18] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset state {out_valid,sum,cout,ovf,in_ready}",
                    {29'h0, out_valid, out_sum, out_cout, out_ovf, in_ready},
                    {29'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1});

        // Latency: an op presented before edge 0 shows out_valid after edge 3.
        @(negedge clock);
        applyStimulus(vecs[16], 1'b1, acc);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clock);
            applyStimulus(idle, 1'b0, acc);
            cyc++;
            if (out_valid) done = 1'b1;
        end
        checkOutput("latency in cycles", 64'(cyc), 64'd4);
        for (int i = 17; i < 19; i++) begin
            @(negedge clock);
            applyStimulus(vecs[i], 1'b1, acc);
        end
        repeat (6) begin
            @(negedge clock);
            applyStimulus(idle, 1'b0, acc);
        end

        // Sixteen back-to-back ops with the consumer always ready.
        validSeen = '0;
        readyLow  = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (i < 16) begin
                applyStimulus(vecs[i], 1'b1, acc);
                if (!acc) readyLow++;
            end else begin
                applyStimulus(idle, 1'b0, acc);
            end
            validSeen[i] = out_valid;
        end
        checkOutput("burst in_ready low cycles", 64'(readyLow), 64'd0);
        checkOutput("burst out_valid pattern", {40'h0, validSeen}, {40'h0, 24'h0FFFF0});

        // Stall: the consumer is blocked while the producer keeps offering ops.
        idx     = 0;
        heldSum = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            out_ready = 1'b0;
            applyStimulus(vecs[idx], 1'b1, acc);
            if (acc) idx++;
            if (i == 4) heldSum = out_sum;
        end
        checkOutput("stall accepted count", 64'(idx), 64'd4);
        checkOutput("stall in_ready", {63'h0, in_ready}, 64'd0);
        checkOutput("stall out_valid", {63'h0, out_valid}, 64'd1);
        checkOutput("stall out_sum held", {32'h0, out_sum}, {32'h0, heldSum});
        checkOutput("stall out_sum value", {32'h0, out_sum}, {32'h0, 32'h00000003});
        for (int guard = 0; guard < 40; guard++) begin
            @(negedge clock);
            out_ready = 1'b1;
            if (idx < 8) begin
                applyStimulus(vecs[idx], 1'b1, acc);
                if (acc) idx++;
            end else begin
                applyStimulus(idle, 1'b0, acc);
                if (sbQ.size() == 0 && !out_valid) break;
            end
        end
        checkOutput("stall drained", 64'(sbQ.size()), 64'd0);

        // Reset with three ops in flight: they must never emerge.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            applyStimulus(vecs[8 + i], 1'b1, acc);
        end
        @(negedge clock);
        reset = 1'b1;
        sbQ.delete();
        applyStimulus(idle, 1'b0, acc);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("mid-op reset {out_valid,sum,cout,ovf,in_ready}",
                    {29'h0, out_valid, out_sum, out_cout, out_ovf, in_ready},
                    {29'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
        stale = 0;
        repeat (8) begin
            @(negedge clock);
            #1;
            if (out_valid) stale++;
        end
        checkOutput("stale results after reset", 64'(stale), 64'd0);

`ifdef PIPELINED_ADDER_SUB_EN
        // Subtraction: 5-7 borrows and 7-5 does not.
        @(negedge clock);
        applyStimulus('{32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0}, 1'b1, acc);
        @(negedge clock);
        applyStimulus('{32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0}, 1'b1, acc);
`endif

        repeat (8) begin
            @(negedge clock);
            applyStimulus(idle, 1'b0, acc);
        end
        checkOutput("scoreboard empty at end", 64'(sbQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
